// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

  localparam int WB_DATA_W = 18;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic RR_ALU = 1'b0;
  localparam logic RR_MEM = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back FIFO: {addr, data} storage with extended pointers plus an
// oldest-first view of the slots so the forwarding scan sees age order across the wrap.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [PTR_W:0]               count_o,
  output logic [ADDR_W-1:0]            head_addr_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic [DEPTH-1:0]             age_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] age_addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0] age_data_o
);

  localparam logic [PTR_W:0]    PTR_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
  logic              push_s, pop_s;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  assign count_s = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_s == PTR_ZERO);
  assign full_o  = (count_s == FULL_CNT);
  assign count_o = count_s;
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  // Pointer advance; push and pop may both happen in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Slot storage: unoccupied slots are masked wherever they are read, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_addr_i;
      data_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

  assign head_addr_o = empty_o ? ADDR_ZERO : addr_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_data_o = empty_o ? DATA_ZERO : data_mem_q[rd_ptr_q[PTR_W-1:0]];

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] idx_s;
    assign idx_s          = rd_ptr_q[PTR_W-1:0] + PTR_W'(k);
    assign age_valid_o[k] = ((PTR_W+1)'(k) < count_s);
    assign age_addr_o[k]  = addr_mem_q[idx_s];
    assign age_data_o[k]  = data_mem_q[idx_s];
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back sequencer: arbitrates ALU and load results into an in-order FIFO,
// drains it onto the register-file write port and serves decode-stage forwarding.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_hold,
  output logic              WE,
  output logic [ADDR_W-1:0] DstAddr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic                         full_s, empty_s, we_s, push_s;
  logic                         alu_grant_s, mem_grant_s;
  logic                         rr_q, rr_d;
  logic [ADDR_W-1:0]            push_addr_s;
  logic [DATA_W-1:0]            push_data_s;
  logic [DEPTH-1:0]             age_valid_s, match_s;
  logic [DEPTH-1:0][ADDR_W-1:0] age_addr_s;
  logic [DEPTH-1:0][DATA_W-1:0] age_data_s;

  // Arbitration: a full FIFO blocks both producers even if it pops this cycle.
  always_comb begin
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    rr_d        = rr_q;
    if (full_s) begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
      rr_d        = rr_q;
    end else if (alu_valid && mem_valid) begin
      alu_grant_s = (rr_q == RR_ALU);
      mem_grant_s = (rr_q == RR_MEM);
      rr_d        = ~rr_q;
    end else begin
      alu_grant_s = alu_valid;
      mem_grant_s = mem_valid;
      rr_d        = rr_q;
    end
  end

  // Round-robin pointer, moves only after a contended grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= RR_ALU;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign push_s      = alu_grant_s || mem_grant_s;
  assign push_addr_s = alu_grant_s ? alu_addr : mem_addr;
  assign push_data_s = alu_grant_s ? alu_data : mem_data;
  assign we_s        = !empty_s && !wb_hold;
  assign alu_ready   = alu_grant_s;
  assign mem_ready   = mem_grant_s;
  assign WE          = we_s;

  wb_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push_s),
    .push_addr_i(push_addr_s),
    .push_data_i(push_data_s),
    .pop_i      (we_s),
    .empty_o    (empty_s),
    .full_o     (full_s),
    .count_o    (count),
    .head_addr_o(DstAddr),
    .head_data_o(wb_data),
    .age_valid_o(age_valid_s),
    .age_addr_o (age_addr_s),
    .age_data_o (age_data_s)
  );

  // Forwarding: scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    match_s  = {DEPTH{1'b0}};
    fwd_hit  = 1'b0;
    fwd_data = DATA_ZERO;
    for (int k = 0; k < DEPTH; k++) begin
      match_s[k] = age_valid_s[k] && (age_addr_s[k] == fwd_addr);
      fwd_hit    = fwd_hit || match_s[k];
      fwd_data   = match_s[k] ? age_data_s[k] : fwd_data;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized traffic
// compared against a queue-based model of the write-back rules.
module tb_reg_writeback;

  localparam int DW = 18;
  localparam int AW = 4;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clock, reset;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, DstAddr, fwd_addr;
  logic [DW-1:0] alu_data, mem_data, wb_data, fwd_data;
  logic          wb_hold, WE, fwd_hit;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Model: pending writes oldest-first as {addr, data}, plus the fairness bit.
  logic [AW+DW-1:0] mq[$];
  logic             mrr;
  logic             p_alu, p_mem, p_we, p_hit;
  logic [AW-1:0]    p_addr;
  logic [DW-1:0]    p_data, p_fdata;
  logic [CW-1:0]    p_cnt;

  reg_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_hold(wb_hold), .WE(WE), .DstAddr(DstAddr), .wb_data(wb_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clock = ~clock;

  task automatic predict();
    int   n;
    logic space;
    n      = mq.size();
    space  = (n < DP);
    p_alu  = space && alu_valid && (!mem_valid || (mrr == 1'b0));
    p_mem  = space && mem_valid && (!alu_valid || (mrr == 1'b1));
    p_we   = (n > 0) && !wb_hold;
    p_addr = (n > 0) ? mq[0][AW+DW-1:DW] : 4'd0;
    p_data = (n > 0) ? mq[0][DW-1:0] : 18'd0;
    p_hit  = 1'b0;
    p_fdata = 18'd0;
    for (int i = 0; i < n; i++) begin
      if (mq[i][AW+DW-1:DW] == fwd_addr) begin
        p_hit   = 1'b1;
        p_fdata = mq[i][DW-1:0];
      end
    end
    p_cnt = CW'(n);
  endtask

  task automatic tick();
    predict();
    @(posedge clock);
    if (reset) begin
      mq.delete();
      mrr = 1'b0;
    end else begin
      if (p_we) mq.delete(0);
      if (p_alu) mq.push_back({alu_addr, alu_data});
      else if (p_mem) mq.push_back({mem_addr, mem_data});
      if ((p_alu || p_mem) && alu_valid && mem_valid) mrr = ~mrr;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wb_hold = 1'b0; fwd_addr = 4'd0;
    alu_valid = 1'b0; alu_addr = 4'd0; alu_data = 18'd0;
    mem_valid = 1'b0; mem_addr = 4'd0; mem_data = 18'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", WE); end
    checks++; if (DstAddr !== 4'd0) begin errors++; $display("FAIL reset_dst got=%0h exp=0", DstAddr); end
    checks++; if (wb_data !== 18'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", wb_data); end
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got=%0b exp=0", fwd_hit); end
    checks++; if ({alu_ready, mem_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready});
    end
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 18'h2A5A5;
    #1;
    checks++; if ({alu_ready, mem_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got=%b exp=10", {alu_ready, mem_ready});
    end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({WE, DstAddr, wb_data} !== {1'b1, 4'd3, 18'h2A5A5}) begin
      errors++; $display("FAIL single_write got=%0b/%0h/%0h exp=1/3/2a5a5", WE, DstAddr, wb_data);
    end
    tick();
    #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", WE); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    logic          eg[4];
    ea = '{4'd1, 4'd9, 4'd2, 4'd10};
    eg = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) ed[i] = (eg[i] ? 18'h00200 : 18'h00100) | {14'd0, ea[i]};
    do_reset();
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 18'h00101;
    mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 18'h00209;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin
        checks++; if ({alu_ready, mem_ready} !== (eg[i] ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL contention_grant%0d got=%b exp=%b", i, {alu_ready, mem_ready},
                              (eg[i] ? 2'b01 : 2'b10));
        end
      end
      if (i > 0) begin
        checks++; if ({WE, DstAddr, wb_data} !== {1'b1, ea[i-1], ed[i-1]}) begin
          errors++; $display("FAIL contention_write%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i - 1,
                              WE, DstAddr, wb_data, ea[i-1], ed[i-1]);
        end
      end
      tick();
      if (i == 0) begin alu_addr = 4'd2; alu_data = 18'h00102; end
      if (i == 1) begin mem_addr = 4'd10; mem_data = 18'h0020A; end
      if (i == 2) alu_valid = 1'b0;
      if (i == 3) mem_valid = 1'b0;
    end
  endtask

  task automatic test_full_hold();
    do_reset();
    wb_hold = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_addr = 4'(i); alu_data = 18'h00300 + 18'(i);
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_accept%0d got=%0b exp=1", i, alu_ready); end
      tick();
    end
    alu_addr = 4'd4; alu_data = 18'h00304;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if ({alu_ready, WE} !== 2'b00) begin
      errors++; $display("FAIL full_blocked got=%b exp=00", {alu_ready, WE});
    end
    tick();
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_frozen got=%0d exp=4", count); end
    wb_hold = 1'b0;
    #1;
    checks++; if ({alu_ready, WE} !== 2'b01) begin
      errors++; $display("FAIL full_pop_noready got=%b exp=01", {alu_ready, WE});
    end
    for (int j = 0; j < 5; j++) begin
      checks++; if ({WE, DstAddr, wb_data} !== {1'b1, 4'(j), 18'h00300 + 18'(j)}) begin
        errors++; $display("FAIL drain%0d got=%0b/%0h/%0h exp=1/%0h/%0h", j, WE, DstAddr, wb_data,
                            j, 18'h00300 + 18'(j));
      end
      if (j == 1) begin
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fifth_accept got=%0b exp=1", alu_ready); end
      end
      tick();
      if (j == 1) alu_valid = 1'b0;
      #1;
    end
    checks++; if ({WE, count} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL drain_done got=%0b/%0d exp=0/0", WE, count);
    end
  endtask

  task automatic test_fwd();
    do_reset();
    wb_hold = 1'b1; alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 18'h00011;
    tick();
    alu_data = 18'h00022;
    tick();
    alu_valid = 1'b0; fwd_addr = 4'd5;
    #1;
    checks++; if ({fwd_hit, fwd_data} !== {1'b1, 18'h00022}) begin
      errors++; $display("FAIL fwd_youngest got=%0b/%0h exp=1/22", fwd_hit, fwd_data);
    end
    checks++; if ({WE, DstAddr, wb_data} !== {1'b0, 4'd5, 18'h00011}) begin
      errors++; $display("FAIL fwd_head_shown got=%0b/%0h/%0h exp=0/5/11", WE, DstAddr, wb_data);
    end
    fwd_addr = 4'd6;
    #1;
    checks++; if ({fwd_hit, fwd_data} !== {1'b0, 18'h00000}) begin
      errors++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", fwd_hit, fwd_data);
    end
    wb_hold = 1'b0; fwd_addr = 4'd5;
    tick();
    #1;
    checks++; if ({fwd_hit, fwd_data} !== {1'b1, 18'h00022}) begin
      errors++; $display("FAIL fwd_after_pop got=%0b/%0h exp=1/22", fwd_hit, fwd_data);
    end
    tick();
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_gone got=%0b exp=0", fwd_hit); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wa[10];
    logic [DW-1:0] wd[10];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wa[i] = 4'((i * 5) % 16);
      wd[i] = 18'($urandom_range(0, 262143));
    end
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        alu_valid = 1'b1; alu_addr = wa[i]; alu_data = wd[i];
      end else begin
        alu_valid = 1'b0;
      end
      #1;
      if (i < 10) begin
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d got=%0b exp=1", i, alu_ready); end
      end
      checks++; if (count > 3'd1) begin errors++; $display("FAIL wrap_count%0d got=%0d exp<=1", i, count); end
      if (i > 0) begin
        checks++; if ({WE, DstAddr, wb_data} !== {1'b1, wa[i-1], wd[i-1]}) begin
          errors++; $display("FAIL wrap_write%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i - 1,
                              WE, DstAddr, wb_data, wa[i-1], wd[i-1]);
        end
      end
      tick();
    end
    #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%0b exp=0", WE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_hold = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_addr = 4'(7 + i); alu_data = 18'h3F000 + 18'(i);
      tick();
    end
    alu_valid = 1'b0; fwd_addr = 4'd7;
    #1;
    checks++; if ({count, fwd_hit} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL mid_prefill got=%0d/%0b exp=3/1", count, fwd_hit);
    end
    reset = 1'b1; wb_hold = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({count, WE, fwd_hit} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got=%0d/%0b/%0b exp=0/0/0", count, WE, fwd_hit);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++; if (WE !== 1'b0) begin errors++; $display("FAIL mid_discard%0d got=%0b exp=0", i, WE); end
    end
  endtask

  task automatic test_random();
    logic [46:0] obs, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 63) == 0);
      alu_valid = ($urandom_range(0, 3) != 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      wb_hold   = ($urandom_range(0, 2) == 0);
      alu_addr  = 4'($urandom_range(0, 15));
      mem_addr  = 4'($urandom_range(0, 15));
      alu_data  = 18'($urandom_range(0, 262143));
      mem_data  = 18'($urandom_range(0, 262143));
      fwd_addr  = 4'($urandom_range(0, 15));
      #1;
      predict();
      obs = {alu_ready, mem_ready, WE, DstAddr, wb_data, fwd_hit, fwd_data, count};
      exp = {p_alu, p_mem, p_we, p_addr, p_data, p_hit, p_fdata, p_cnt};
      checks++; if (obs !== exp) begin
        errors++; $display("FAIL random%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    clock = 1'b0; mrr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_full_hold();
    test_fwd();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
